vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 13, video RAM address width; DW, default 8, data width; WAIT_SAT, default 255, saturation limit of the contention counter.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock (25 MHz video clock)
- rst_n  in  1  async active-low reset
- ula_req  in  1  ULA fetch request, this cycle
- ula_addr  in  AW  ULA fetch address
- cpu_req  in  1  CPU access request, level, held until ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- cpu_wait  out  1  CPU stalled by ULA this cycle (Z80 WAIT source)
- wait_cnt  out  8  saturating count of stalled cycles for current request
- mem_addr  out  AW  video RAM address
- mem_we  out  1  video RAM write enable
- mem_wdata  out  DW  video RAM write data
- mem_rdata  in  DW  video RAM read data, synchronous RAM, one-cycle latency

Function
REQ-004 The ULA SHALL have absolute priority: when ula_req=1, mem_addr=ula_addr and mem_we=0 in the same cycle (combinational mux), so the ULA address-to-data timing is one edge.
REQ-005 The FSM SHALL have states IDLE, ACCESS and HOLD.
REQ-006 IDLE: if cpu_req=1 and ula_req=0, then mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, and next state is ACCESS; if cpu_req=1 and ula_req=1, stay in IDLE with cpu_wait=1.
REQ-007 ACCESS: the bus SHALL be free for the ULA. For a read, cpu_rdata SHALL capture mem_rdata at the end of ACCESS. cpu_ready SHALL pulse high for exactly the first cycle of HOLD. Next state is HOLD regardless of cpu_req.
REQ-008 HOLD: next state is IDLE when cpu_req=0, otherwise stay; a request held high after ready SHALL NOT start a second access.
REQ-009 mem_we SHALL be 1 only in an IDLE grant cycle with cpu_we=1; it SHALL never be 1 while ula_req=1.
REQ-010 cpu_wait SHALL be combinational: 1 iff state=IDLE, cpu_req=1 and ula_req=1.
REQ-011 wait_cnt SHALL increment on each cpu_wait cycle, saturate at WAIT_SAT, and clear to 0 on the cycle cpu_ready is high.
REQ-012 cpu_req dropping in ACCESS: the memory cycle SHALL complete (a write is already committed) and cpu_ready SHALL still pulse; HOLD then exits to IDLE on the following cycle.
REQ-013 When no requester is active, mem_addr SHALL hold cpu_addr and mem_we SHALL be 0.
REQ-014 cpu_rdata SHALL hold its last value on writes and when idle.

Reset
REQ-015 While rst_n=0: state=IDLE, cpu_ready=0, cpu_rdata=0, wait_cnt=0; combinational outputs follow REQ-004/010/013.
REQ-016 Reset asserted mid-ACCESS SHALL abort with no cpu_ready pulse; after release, a still-high cpu_req SHALL be re-arbitrated from IDLE.

Structure
REQ-017 The state encoding and the default AW/DW SHALL live in shared package video_pkg, reused by the ULA and CPU bus glue.
REQ-018 No sub-module is required; the saturating counter MAY be factored as sat_counter.

Verification
REQ-019 Idle CPU read: RAM[0x0123]=0xA5, cpu_req=1, cpu_we=0, ula_req=0 -> ACCESS next cycle, cpu_rdata=0xA5, cpu_ready pulse 2 cycles after req, wait_cnt=0.
REQ-020 Contention: cpu_req=1 while ula_req=1 for 2 cycles -> cpu_wait=1 for 2 cycles, grant on cycle 3, wait_cnt=2 until ready, then 0.
REQ-021 Write under ULA traffic: ULA requests at x[3:0]=0 and 2 every 16 cycles; CPU writes 0x5A to 0x1800 -> mem_we never coincides with ula_req; readback returns 0x5A.
REQ-022 Held request: cpu_req held 10 cycles after ready -> exactly one cpu_ready pulse and one mem_we.
REQ-023 Reset in ACCESS: rst_n low for 1 cycle -> no cpu_ready pulse; after release with cpu_req=1, a fresh access completes.
REQ-024 Saturation: ula_req held high for 300 cycles with cpu_req=1 -> wait_cnt=255; after ula_req falls, ready pulses and wait_cnt returns to 0.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video-subsystem defaults and arbiter state encoding
package video_pkg;

  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;
  localparam int WAIT_W  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_HOLD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter
  import video_pkg::*;
#(
  parameter int W   = WAIT_W,
  parameter int SAT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] SAT_V = W'(SAT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment so a completing access always leaves the count at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < SAT_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video RAM arbiter, ULA fetches pre-empt CPU accesses
module vram_arbiter
  import video_pkg::*;
#(
  parameter int AW       = VRAM_AW,
  parameter int DW       = VRAM_DW,
  parameter int WAIT_SAT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ula_req,
  input  logic [AW-1:0] ula_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_wait,
  output logic [7:0]    wait_cnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_q;
  logic          ready_q;
  logic          rd_q;
  logic [DW-1:0] rdata_q;
  logic          grant;

  assign grant    = (state_q == ARB_IDLE) && cpu_req && !ula_req;
  assign cpu_wait = (state_q == ARB_IDLE) && cpu_req && ula_req;

  // The ULA owns the address bus whenever it asks; otherwise the CPU address is parked there.
  assign mem_addr  = ula_req ? ula_addr : cpu_addr;
  assign mem_we    = grant && cpu_we;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ready_q <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            rd_q    <= !cpu_we;
            state_q <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // RAM output now carries the word addressed in the grant cycle.
          if (rd_q) begin
            rdata_q <= mem_rdata;
          end
          ready_q <= 1'b1;
          state_q <= ARB_HOLD;
        end
        ARB_HOLD: begin
          if (!cpu_req) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign cpu_ready = ready_q;
  assign cpu_rdata = rdata_q;

  sat_counter #(
    .W   (8),
    .SAT (WAIT_SAT)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == ARB_ACCESS),
    .inc_i   (cpu_wait),
    .count_o (wait_cnt)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized transaction-level bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ula_req;
  logic [12:0] ula_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        cpu_wait;
  logic [7:0]  wait_cnt;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram     [0:8191];
  logic [7:0]  ref_mem [0:8191];
  logic [7:0]  last_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          gcyc    = 0;

  vram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ula_req   (ula_req),
    .ula_addr  (ula_addr),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_wait  (cpu_wait),
    .wait_cnt  (wait_cnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #20 clk = ~clk;

  // Synchronous single-port video RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    gcyc      <= gcyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ula_bg(input int mode);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      3:       return ((gcyc % 16) == 0) || ((gcyc % 16) == 2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ula_pick(input int mode, input int cyc, input int stall_n);
    if (mode == 2) return (cyc < stall_n);
    return ula_bg(mode);
  endfunction

  task automatic drive_ula(input bit b);
    ula_req  = b;
    ula_addr = 13'($urandom);
  endtask

  // One CPU transaction; the model only knows: stall while ULA asks, grant when it does not,
  // ready two cycles after grant, one access per request.
  task automatic do_access(input bit we, input logic [12:0] addr, input logic [7:0] wd,
                           input int mode, input int stall_n, input int hold_extra, input bit drop);
    int   stalls;
    bit   granted;
    logic [7:0] exp_rd;
    stalls    = 0;
    granted   = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    for (int cyc = 0; cyc < 400 && !granted; cyc++) begin
      drive_ula(ula_pick(mode, cyc, stall_n));
      @(negedge clk);
      check("ready_while_waiting", cpu_ready, 0);
      check("wait_cnt_waiting", wait_cnt, (stalls > 255) ? 255 : stalls);
      if (ula_req) begin
        check("cpu_wait_hi", cpu_wait, 1);
        check("mem_addr_ula", mem_addr, ula_addr);
        check("mem_we_ula", mem_we, 0);
        stalls++;
      end else begin
        check("cpu_wait_lo", cpu_wait, 0);
        check("mem_addr_grant", mem_addr, addr);
        check("mem_we_grant", mem_we, we);
        if (we) check("mem_wdata_grant", mem_wdata, wd);
        granted = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("granted", granted, 1);
    if (!granted) begin
      cpu_req = 1'b0;
      return;
    end
    if (we) ref_mem[addr] = wd;
    exp_rd = we ? last_rdata : ref_mem[addr];

    if (drop) cpu_req = 1'b0;
    drive_ula(ula_bg(mode));
    @(negedge clk);
    check("ready_access", cpu_ready, 0);
    check("wait_access", cpu_wait, 0);
    check("mem_we_access", mem_we, 0);
    check("mem_addr_access", mem_addr, ula_req ? ula_addr : addr);
    @(posedge clk); #1;

    drive_ula(ula_bg(mode));
    @(negedge clk);
    check("ready_pulse", cpu_ready, 1);
    check("wait_cnt_cleared", wait_cnt, 0);
    check("rdata", cpu_rdata, exp_rd);
    check("mem_we_hold", mem_we, 0);
    check("wait_hold", cpu_wait, 0);
    last_rdata = exp_rd;
    @(posedge clk); #1;

    if (!drop) begin
      for (int i = 0; i < hold_extra; i++) begin
        drive_ula(ula_bg(mode));
        @(negedge clk);
        check("ready_held", cpu_ready, 0);
        check("mem_we_held", mem_we, 0);
        check("wait_held", cpu_wait, 0);
        check("rdata_held", cpu_rdata, last_rdata);
        @(posedge clk); #1;
      end
      cpu_req = 1'b0;
      drive_ula(ula_bg(mode));
      @(negedge clk);
      check("ready_release", cpu_ready, 0);
      check("mem_we_release", mem_we, 0);
      @(posedge clk); #1;
    end

    drive_ula(1'b0);
    @(negedge clk);
    check("idle_mem_addr", mem_addr, addr);
    check("idle_mem_we", mem_we, 0);
    check("idle_ready", cpu_ready, 0);
    check("idle_rdata", cpu_rdata, last_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[13'h0123]     = 8'hA5;
    ref_mem[13'h0123] = 8'hA5;
    last_rdata = 8'h00;

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 13'h0ABC;
    cpu_wdata = 8'h00;
    drive_ula(1'b0);
    @(negedge clk);
    check("rst_ready", cpu_ready, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 13'h0ABC);
    cpu_req = 1'b1;
    drive_ula(1'b1);
    #1;
    check("rst_cpu_wait", cpu_wait, 1);
    check("rst_mem_addr_ula", mem_addr, ula_addr);
    cpu_req = 1'b0;
    drive_ula(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 13'h0123, 8'h00, 0, 0, 0, 1'b0);
    check("idle_read_a5", cpu_rdata, 8'hA5);
    do_access(1'b0, 13'h0200, 8'h00, 2, 2, 0, 1'b0);
    do_access(1'b1, 13'h1800, 8'h5A, 3, 0, 0, 1'b0);
    do_access(1'b0, 13'h1800, 8'h00, 3, 0, 0, 1'b0);
    check("readback_5a", cpu_rdata, 8'h5A);
    do_access(1'b1, 13'h0042, 8'hC3, 0, 0, 10, 1'b0);
    do_access(1'b1, 13'h0777, 8'h3C, 1, 0, 0, 1'b1);
    do_access(1'b0, 13'h0777, 8'h00, 0, 0, 0, 1'b1);

    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 13'h0456;
    drive_ula(1'b0);
    @(negedge clk);
    check("pre_reset_grant", mem_addr, 13'h0456);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", cpu_ready, 0);
    check("abort_rdata", cpu_rdata, 0);
    check("abort_wait_cnt", wait_cnt, 0);
    last_rdata = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_access(1'b0, 13'h0456, 8'h00, 0, 0, 0, 1'b0);

    do_access(1'b0, 13'h0123, 8'h00, 2, 300, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      do_access(1'($urandom_range(0, 1)), 13'($urandom_range(0, 15) * 16 + 5), 8'($urandom),
                ($urandom_range(0, 1) != 0) ? 3 : 1, 0, $urandom_range(0, 3),
                1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
